shift_pipe: RTL

Two-stage pipelined 32-bit shifter for the processor's execute path. Accepts an operand, 5-bit shift amount and shift op under a valid/ready handshake, performs the logarithmic shift across two registered stages, and returns the result with the caller's destination tag. It takes operands from the ALU operand-select logic and hands results to writeback arbitration, so shifts leave the single-cycle ALU critical path.

---
 rtl/shift_pkg.sv | 23 ++
 rtl/shift_stage.sv | 28 ++
 rtl/shift_pipe.sv | 113 +++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and constants for the two-stage pipelined shifter.
package shift_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned TAG_W_DEFAULT = 5;
  localparam int unsigned SHAMT_W       = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRA  = 2'b01,
    SHIFT_SRL  = 2'b10,
    SHIFT_PASS = 2'b11
  } shift_op_e;

  // Stage-A payload: partially shifted data plus what stage B still needs.
  typedef struct packed {
    logic [WIDTH_DEFAULT-1:0] data;
    logic [2:0]               shamt_lo;
    shift_op_e                op;
    logic [TAG_W_DEFAULT-1:0] tag;
  } stage_a_t;

endpackage

// File: rtl/shift_stage.sv
// Combinational fixed-amount conditional shifter; one rung of the log shifter.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_en,
  input  shift_op_e        i_op,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      unique case (i_op)
        SHIFT_SLL:  o_data = i_data << AMT;
        // MSB is the original sign at every rung, since SRA never alters it.
        SHIFT_SRA:  o_data = {{AMT{i_data[WIDTH-1]}}, i_data[WIDTH-1:AMT]};
        SHIFT_SRL:  o_data = i_data >> AMT;
        SHIFT_PASS: o_data = i_data;
        default:    o_data = i_data;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage pipelined 32-bit shifter with valid/ready handshake and tag pass-through.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned TAG_W = TAG_W_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  logic             r_valid_a;
  stage_a_t         r_a;
  logic             r_valid_b;
  logic [WIDTH-1:0] r_data_b;
  logic [TAG_W-1:0] r_tag_b;

  logic             w_adv_a;
  logic             w_adv_b;
  shift_op_e        w_op;
  logic [WIDTH-1:0] w_s16;
  logic [WIDTH-1:0] w_s8;
  logic [WIDTH-1:0] w_s4;
  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] w_s1;
  stage_a_t         w_a_next;

  assign w_adv_b  = !r_valid_b || out_ready;
  assign w_adv_a  = !r_valid_a || w_adv_b;
  assign in_ready = w_adv_a;
  assign w_op     = shift_op_e'(in_op);

  shift_stage #(.WIDTH(WIDTH), .AMT(16)) u_s16 (
    .i_data (in_data),
    .i_en   (in_shamt[4]),
    .i_op   (w_op),
    .o_data (w_s16)
  );

  shift_stage #(.WIDTH(WIDTH), .AMT(8)) u_s8 (
    .i_data (w_s16),
    .i_en   (in_shamt[3]),
    .i_op   (w_op),
    .o_data (w_s8)
  );

  always_comb begin
    w_a_next          = '0;
    w_a_next.data     = w_s8;
    w_a_next.shamt_lo = in_shamt[2:0];
    w_a_next.op       = w_op;
    w_a_next.tag      = in_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_a <= 1'b0;
      r_a       <= '0;
    end else if (w_adv_a) begin
      // adv_a already holds here, so the accept condition reduces to in_valid.
      r_valid_a <= in_valid;
      r_a       <= w_a_next;
    end
  end

  shift_stage #(.WIDTH(WIDTH), .AMT(4)) u_s4 (
    .i_data (r_a.data),
    .i_en   (r_a.shamt_lo[2]),
    .i_op   (r_a.op),
    .o_data (w_s4)
  );

  shift_stage #(.WIDTH(WIDTH), .AMT(2)) u_s2 (
    .i_data (w_s4),
    .i_en   (r_a.shamt_lo[1]),
    .i_op   (r_a.op),
    .o_data (w_s2)
  );

  shift_stage #(.WIDTH(WIDTH), .AMT(1)) u_s1 (
    .i_data (w_s2),
    .i_en   (r_a.shamt_lo[0]),
    .i_op   (r_a.op),
    .o_data (w_s1)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_b <= 1'b0;
      r_data_b  <= '0;
      r_tag_b   <= '0;
    end else if (w_adv_b) begin
      r_valid_b <= r_valid_a;
      r_data_b  <= w_s1;
      r_tag_b   <= r_a.tag;
    end
  end

  assign out_valid = r_valid_b;
  assign out_data  = r_data_b;
  assign out_tag   = r_tag_b;

endmodule
